// File: rtl/tbird_pkg.sv
// T-Bird tail-light sequencer shared types.
// Mode encoding doubles as the {s1,s0} pair.
package tbird_pkg;

    typedef enum logic [1:0] {
        MODE_IDLE  = 2'b00,
        MODE_RIGHT = 2'b01,
        MODE_LEFT  = 2'b10,
        MODE_ERR   = 2'b11
    } mode_t;

    localparam int PHASE_W = 2;
    typedef logic [PHASE_W-1:0] phase_t;

    localparam phase_t PH_0 = 2'd0;
    localparam phase_t PH_1 = 2'd1;
    localparam phase_t PH_2 = 2'd2;
    localparam phase_t PH_3 = 2'd3;

    localparam logic [1:0] BRAKE_CODE = 2'b11;

    function automatic logic is_run(mode_t m);
        return (m == MODE_LEFT) || (m == MODE_RIGHT);
    endfunction

endpackage

// File: rtl/tbird_if.sv
// Switch inputs and lamp-decoder outputs of the sequencer.
// The sequencer is the slave; the switch/decoder side is the master.
interface tbird_if;
    logic       sw_left;
    logic       sw_right;
    logic       sw_brake;
    logic       s1;
    logic       s0;
    logic [3:0] a;
    logic       step;

    modport master (
        output sw_left, sw_right, sw_brake,
        input  s1, s0, a, step
    );

    modport slave (
        input  sw_left, sw_right, sw_brake,
        output s1, s0, a, step
    );
endinterface

// File: rtl/tbird_tick_gen.sv
// Free-running animation tick divider.
// tick is high while the count sits at TICK_DIV-1.
module tbird_tick_gen #(
    parameter int TICK_DIV = 12500000
) (
    input  logic clk,
    input  logic reset_n,
    input  logic clear,
    output logic tick
);

    localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

    logic [CW-1:0] cnt;

    assign tick = (cnt == LAST);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt <= '0;
        end else if (clear || tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

endmodule

// File: rtl/tbird_sequencer.sv
// T-Bird mode FSM: synchronizes switches, steps the
// animation phase and registers {s1,s0} and a[3:0].
module tbird_sequencer
    import tbird_pkg::*;
#(
    parameter int TICK_DIV    = 12500000,
    parameter int SYNC_STAGES = 2
) (
    input logic   clk,
    input logic   reset_n,
    tbird_if.slave bus
);

    logic [2:0] sw_raw;
    logic [2:0] sw_sync;

    assign sw_raw = {bus.sw_left, bus.sw_right, bus.sw_brake};

    for (genvar g = 0; g < SYNC_STAGES; g++) begin : g_sync
        logic [2:0] d;
        logic [2:0] q;
        if (g == 0) begin : g_in
            assign d = sw_raw;
        end else begin : g_chain
            assign d = g_sync[g-1].q;
        end
        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) q <= '0;
            else          q <= d;
        end
    end

    assign sw_sync = g_sync[SYNC_STAGES-1].q;

    mode_t      mode_q;
    mode_t      mode_d;
    phase_t     phase_q;
    phase_t     phase_d;
    logic [1:0] brk;
    logic [3:0] a_q;
    logic       step_q;
    logic       chg;
    logic       tick;
    logic       adv;

    assign mode_d = mode_t'(sw_sync[2:1]);
    assign chg    = (mode_d != mode_q);
    // A mode change wins over a coincident tick.
    assign adv    = !chg && tick && is_run(mode_q);
    assign brk    = (sw_sync[0] && mode_d != MODE_ERR) ? BRAKE_CODE : 2'b00;

    always_comb begin
        phase_d = phase_q;
        if (chg)      phase_d = PH_0;
        else if (adv) phase_d = phase_q + PH_1;
    end

    tbird_tick_gen #(
        .TICK_DIV (TICK_DIV)
    ) u_tick (
        .clk     (clk),
        .reset_n (reset_n),
        .clear   (chg),
        .tick    (tick)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mode_q  <= MODE_IDLE;
            phase_q <= PH_0;
            a_q     <= 4'b0000;
            step_q  <= 1'b0;
        end else begin
            mode_q  <= mode_d;
            phase_q <= phase_d;
            step_q  <= adv;
            a_q     <= {brk, is_run(mode_d) ? phase_d : PH_0};
        end
    end

    assign bus.s1   = mode_q[1];
    assign bus.s0   = mode_q[0];
    assign bus.a    = a_q;
    assign bus.step = step_q;

endmodule

// File: tb/tb_tbird_sequencer.sv
// Directed bench for tbird_sequencer with TICK_DIV=4.
// Observed vector is {s1,s0,a[3:0],step}.
module tb_tbird_sequencer;

    logic clk;
    logic reset_n;
    int   n_checks;
    int   n_fail;

    tbird_if bus ();

    tbird_sequencer #(
        .TICK_DIV    (4),
        .SYNC_STAGES (2)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    logic [6:0] obs;
    assign obs = {bus.s1, bus.s0, bus.a, bus.step};

    always #5 clk = ~clk;

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic set_sw(input logic l, input logic r, input logic b);
        bus.sw_left  = l;
        bus.sw_right = r;
        bus.sw_brake = b;
    endtask

    task automatic apply_reset();
        reset_n = 1'b0;
        set_sw(0, 0, 0);
        cyc(2);
        reset_n = 1'b1;
    endtask

    task automatic test_reset();
        logic [2:0] v;
        reset_n = 1'b0;
        for (int i = 0; i < 6; i++) begin
            v = 3'(i + 3);
            set_sw(v[2], v[1], v[0]);
            cyc(1);
            n_checks++;
            if (obs !== 7'b0) begin
                n_fail++;
                $display("FAIL reset_hold: got %b expected %b", obs, 7'b0);
            end
        end
        set_sw(0, 0, 0);
        reset_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            cyc(1);
            n_checks++;
            if (obs !== 7'b0) begin
                n_fail++;
                $display("FAIL idle_release: got %b expected %b", obs, 7'b0);
            end
        end
    endtask

    task automatic test_right_cycle();
        logic [6:0] exp;
        logic [1:0] ph;
        apply_reset();
        set_sw(0, 1, 0);
        cyc(2);
        n_checks++;
        if (obs !== 7'b0) begin
            n_fail++;
            $display("FAIL right_early: got %b expected %b", obs, 7'b0);
        end
        cyc(1);
        n_checks++;
        if (obs !== 7'b01_0000_0) begin
            n_fail++;
            $display("FAIL right_latency: got %b expected %b", obs, 7'b01_0000_0);
        end
        for (int k = 1; k <= 16; k++) begin
            cyc(1);
            ph  = 2'(k / 4);
            exp = {2'b01, 2'b00, ph, (k % 4) == 0};
            n_checks++;
            if (obs !== exp) begin
                n_fail++;
                $display("FAIL right_step k=%0d: got %b expected %b", k, obs, exp);
            end
        end
    endtask

    task automatic test_err_then_left();
        apply_reset();
        set_sw(0, 1, 0);
        cyc(3);
        cyc(8);
        n_checks++;
        if (obs !== 7'b01_0010_1) begin
            n_fail++;
            $display("FAIL right_ph2: got %b expected %b", obs, 7'b01_0010_1);
        end
        set_sw(1, 1, 0);
        cyc(2);
        n_checks++;
        if (obs !== 7'b01_0010_0) begin
            n_fail++;
            $display("FAIL err_early: got %b expected %b", obs, 7'b01_0010_0);
        end
        cyc(1);
        n_checks++;
        if (obs !== 7'b11_0000_0) begin
            n_fail++;
            $display("FAIL err_entry: got %b expected %b", obs, 7'b11_0000_0);
        end
        for (int i = 0; i < 8; i++) begin
            cyc(1);
            n_checks++;
            if (obs !== 7'b11_0000_0) begin
                n_fail++;
                $display("FAIL err_hold i=%0d: got %b expected %b", i, obs, 7'b11_0000_0);
            end
        end
        set_sw(1, 0, 0);
        cyc(3);
        n_checks++;
        if (obs !== 7'b10_0000_0) begin
            n_fail++;
            $display("FAIL left_entry: got %b expected %b", obs, 7'b10_0000_0);
        end
        for (int i = 0; i < 3; i++) begin
            cyc(1);
            n_checks++;
            if (obs !== 7'b10_0000_0) begin
                n_fail++;
                $display("FAIL left_hold i=%0d: got %b expected %b", i, obs, 7'b10_0000_0);
            end
        end
        cyc(1);
        n_checks++;
        if (obs !== 7'b10_0001_1) begin
            n_fail++;
            $display("FAIL left_adv: got %b expected %b", obs, 7'b10_0001_1);
        end
    endtask

    task automatic test_brake();
        apply_reset();
        set_sw(1, 0, 0);
        cyc(3);
        cyc(4);
        n_checks++;
        if (obs !== 7'b10_0001_1) begin
            n_fail++;
            $display("FAIL brk_pre: got %b expected %b", obs, 7'b10_0001_1);
        end
        set_sw(1, 0, 1);
        cyc(2);
        n_checks++;
        if (obs !== 7'b10_0001_0) begin
            n_fail++;
            $display("FAIL brk_early: got %b expected %b", obs, 7'b10_0001_0);
        end
        cyc(1);
        n_checks++;
        if (obs !== 7'b10_1101_0) begin
            n_fail++;
            $display("FAIL brk_left: got %b expected %b", obs, 7'b10_1101_0);
        end
        cyc(1);
        n_checks++;
        if (obs !== 7'b10_1110_1) begin
            n_fail++;
            $display("FAIL brk_left_adv: got %b expected %b", obs, 7'b10_1110_1);
        end
        set_sw(0, 0, 1);
        cyc(3);
        n_checks++;
        if (obs !== 7'b00_1100_0) begin
            n_fail++;
            $display("FAIL brk_idle: got %b expected %b", obs, 7'b00_1100_0);
        end
        cyc(5);
        n_checks++;
        if (obs !== 7'b00_1100_0) begin
            n_fail++;
            $display("FAIL brk_idle_hold: got %b expected %b", obs, 7'b00_1100_0);
        end
        set_sw(1, 1, 1);
        cyc(3);
        n_checks++;
        if (obs !== 7'b11_0000_0) begin
            n_fail++;
            $display("FAIL brk_err: got %b expected %b", obs, 7'b11_0000_0);
        end
        cyc(4);
        n_checks++;
        if (obs !== 7'b11_0000_0) begin
            n_fail++;
            $display("FAIL brk_err_hold: got %b expected %b", obs, 7'b11_0000_0);
        end
        set_sw(0, 0, 0);
        cyc(3);
        n_checks++;
        if (obs !== 7'b0) begin
            n_fail++;
            $display("FAIL brk_off: got %b expected %b", obs, 7'b0);
        end
    endtask

    task automatic test_tick_collision();
        apply_reset();
        set_sw(0, 1, 0);
        cyc(3);
        cyc(1);
        set_sw(1, 0, 0);
        cyc(2);
        n_checks++;
        if (obs !== 7'b01_0000_0) begin
            n_fail++;
            $display("FAIL coll_pre: got %b expected %b", obs, 7'b01_0000_0);
        end
        cyc(1);
        n_checks++;
        if (obs !== 7'b10_0000_0) begin
            n_fail++;
            $display("FAIL coll_no_step: got %b expected %b", obs, 7'b10_0000_0);
        end
        cyc(3);
        n_checks++;
        if (obs !== 7'b10_0000_0) begin
            n_fail++;
            $display("FAIL coll_hold: got %b expected %b", obs, 7'b10_0000_0);
        end
        cyc(1);
        n_checks++;
        if (obs !== 7'b10_0001_1) begin
            n_fail++;
            $display("FAIL coll_adv: got %b expected %b", obs, 7'b10_0001_1);
        end
    endtask

    task automatic test_async_reset();
        apply_reset();
        set_sw(0, 1, 0);
        cyc(3);
        cyc(12);
        n_checks++;
        if (obs !== 7'b01_0011_1) begin
            n_fail++;
            $display("FAIL ar_ph3: got %b expected %b", obs, 7'b01_0011_1);
        end
        cyc(1);
        #3;
        reset_n = 1'b0;
        #1;
        n_checks++;
        if (obs !== 7'b0) begin
            n_fail++;
            $display("FAIL async_reset: got %b expected %b", obs, 7'b0);
        end
        cyc(2);
        reset_n = 1'b1;
        cyc(2);
        n_checks++;
        if (obs !== 7'b0) begin
            n_fail++;
            $display("FAIL ar_release: got %b expected %b", obs, 7'b0);
        end
        cyc(1);
        n_checks++;
        if (obs !== 7'b01_0000_0) begin
            n_fail++;
            $display("FAIL ar_restart: got %b expected %b", obs, 7'b01_0000_0);
        end
        cyc(4);
        n_checks++;
        if (obs !== 7'b01_0001_1) begin
            n_fail++;
            $display("FAIL ar_adv: got %b expected %b", obs, 7'b01_0001_1);
        end
    endtask

    initial begin
        clk      = 1'b0;
        reset_n  = 1'b0;
        n_checks = 0;
        n_fail   = 0;
        set_sw(0, 0, 0);
        test_reset();
        test_right_cycle();
        test_err_then_left();
        test_brake();
        test_tick_collision();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
